conv3x3_stream_filter: RTL and testbench

Parametrised streaming 3x3 neighbourhood filter for raster-order pixel streams. It contains its own two line buffers, so it takes one pixel per valid cycle instead of three pre-aligned rows. The filter mode is selectable per frame: gaussian, box mean, Laplacian edge magnitude, or bypass. It sits between the pixel source and the downstream image pipeline stages, and it signals end of frame.

---
 rtl/conv3x3_stream_filter.sv | 159 +++++++++++++++
 tb/tb_conv3x3_stream_filter.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/conv3x3_stream_filter.sv
// Streaming 3x3 neighbourhood filter with internal line buffers.
// Modes: gaussian 1-2-1, box mean, Laplacian magnitude, or bypass of the centre pixel.
module conv3x3_stream_filter #(
    parameter int DW    = 8,
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          sof_i,
    input  logic          vld_i,
    input  logic [DW-1:0] pix_i,
    input  logic [1:0]    mode_i,
    output logic          vld_o,
    output logic [DW-1:0] pix_o,
    output logic          done_o
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    logic          w_sof;
    logic [CW-1:0] w_col;
    logic [RW-1:0] w_row;
    logic [1:0]    w_mode;
    logic [DW-1:0] w_top, w_mid;

    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;
    logic [1:0]    r_mode;
    logic [DW-1:0] r_lb1 [IMG_W];
    logic [DW-1:0] r_lb2 [IMG_W];
    logic [DW-1:0] r_win [3][3];

    logic          r_v0, r_d0, r_v1, r_d1, r_v2, r_d2;
    logic [1:0]    r_m0, r_m1, r_m2;
    logic [DW+1:0] r_g [3];
    logic [DW+1:0] r_b [3];
    logic [DW-1:0] r_c1, r_c2;
    logic [DW+3:0] r_gs, r_bs;

    // A qualified sof forces the current pixel to (0,0) and re-samples the mode.
    assign w_sof  = vld_i & sof_i;
    assign w_col  = w_sof ? '0 : r_col;
    assign w_row  = w_sof ? '0 : r_row;
    assign w_mode = w_sof ? mode_i : r_mode;
    assign w_top  = r_lb2[w_col];
    assign w_mid  = r_lb1[w_col];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col  <= '0;
            r_row  <= '0;
            r_mode <= 2'd0;
        end else if (vld_i) begin
            r_mode <= w_mode;
            if (w_col == CW'(IMG_W - 1)) begin
                r_col <= '0;
                r_row <= (w_row == RW'(IMG_H - 1)) ? '0 : w_row + 1'b1;
            end else begin
                r_col <= w_col + 1'b1;
                r_row <= w_row;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (vld_i) begin
            r_lb1[w_col] <= pix_i;
            r_lb2[w_col] <= w_mid;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                    r_win[i][j] <= '0;
            r_v0 <= 1'b0;
            r_d0 <= 1'b0;
            r_m0 <= 2'd0;
        end else begin
            if (vld_i) begin
                for (int i = 0; i < 3; i++) begin
                    r_win[i][0] <= r_win[i][1];
                    r_win[i][1] <= r_win[i][2];
                end
                r_win[0][2] <= w_top;
                r_win[1][2] <= w_mid;
                r_win[2][2] <= pix_i;
            end
            r_v0 <= vld_i && (w_row >= RW'(2)) && (w_col >= CW'(2));
            r_d0 <= vld_i && (w_row == RW'(IMG_H - 1)) && (w_col == CW'(IMG_W - 1));
            r_m0 <= w_mode;
        end
    end

    // Free-running arithmetic pipeline; only the valid bits need a reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1 <= 1'b0;
            r_d1 <= 1'b0;
            r_v2 <= 1'b0;
            r_d2 <= 1'b0;
        end else begin
            r_v1 <= r_v0;
            r_d1 <= r_d0 & r_v0;
            r_v2 <= r_v1;
            r_d2 <= r_d1 & r_v1;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            r_g[i] <= (DW+2)'(r_win[i][0]) + ((DW+2)'(r_win[i][1]) << 1) + (DW+2)'(r_win[i][2]);
            r_b[i] <= (DW+2)'(r_win[i][0]) + (DW+2)'(r_win[i][1]) + (DW+2)'(r_win[i][2]);
        end
        r_c1 <= r_win[1][1];
        r_m1 <= r_m0;
        r_gs <= (DW+4)'(r_g[0]) + ((DW+4)'(r_g[1]) << 1) + (DW+4)'(r_g[2]);
        r_bs <= (DW+4)'(r_b[0]) + (DW+4)'(r_b[1]) + (DW+4)'(r_b[2]);
        r_c2 <= r_c1;
        r_m2 <= r_m1;
    end

    function automatic logic [DW-1:0] sat(input logic [DW+9:0] x);
        return (|x[DW+9:DW]) ? {DW{1'b1}} : x[DW-1:0];
    endfunction

    logic [DW+3:0] w_nine_c, w_diff;
    logic [DW+9:0] w_box_prod;
    logic [DW-1:0] w_res;

    // Laplacian as |9*centre - sum9|, which equals |8*centre - neighbours|.
    always_comb begin
        w_nine_c   = ((DW+4)'(r_c2) << 3) + (DW+4)'(r_c2);
        w_diff     = (w_nine_c >= r_bs) ? (w_nine_c - r_bs) : (r_bs - w_nine_c);
        w_box_prod = (DW+10)'(r_bs) * (DW+10)'(57);
        w_res      = r_c2;
        case (r_m2)
            2'd0:    w_res = sat((DW+10)'(r_gs >> 4));
            2'd1:    w_res = sat(w_box_prod >> 9);
            2'd2:    w_res = sat((DW+10)'(w_diff));
            default: w_res = r_c2;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_o  <= 1'b0;
            done_o <= 1'b0;
            pix_o  <= '0;
        end else begin
            vld_o  <= r_v2;
            done_o <= r_d2 & r_v2;
            if (r_v2)
                pix_o <= w_res;
        end
    end
endmodule

// File: tb/tb_conv3x3_stream_filter.sv
// Randomised bench for conv3x3_stream_filter on an 8x4 frame with a
// frame-level reference model and a timestamped expected-output queue.
module tb_conv3x3_stream_filter;
    localparam int DW = 8;
    localparam int W  = 8;
    localparam int H  = 4;
    localparam int P  = 10;

    logic          clk, rst_n, sof_i, vld_i;
    logic [DW-1:0] pix_i;
    logic [1:0]    mode_i;
    logic          vld_o, done_o;
    logic [DW-1:0] pix_o;

    conv3x3_stream_filter #(.DW(DW), .IMG_W(W), .IMG_H(H)) dut (
        .clk(clk), .rst_n(rst_n), .sof_i(sof_i), .vld_i(vld_i), .pix_i(pix_i),
        .mode_i(mode_i), .vld_o(vld_o), .pix_o(pix_o), .done_o(done_o)
    );

    initial clk = 1'b0;
    always #(P/2) clk = ~clk;

    typedef struct { int px; int dn; longint t; } exp_t;
    exp_t exp_q[$];

    int n_chk  = 0;
    int n_pass = 0;
    int img [H][W];
    int m_r = 0, m_c = 0, m_mode = 0;
    int n_done = 0;

    task automatic chk(input string tag, input longint got, input longint want);
        n_chk++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, want);
    endtask

    function automatic int model_px(int md, int r, int c);
        int s, v, ctr;
        s = 0;
        ctr = img[r][c];
        for (int dr = -1; dr <= 1; dr++)
            for (int dc = -1; dc <= 1; dc++)
                if (md == 0) s += img[r+dr][c+dc] * (dr == 0 ? 2 : 1) * (dc == 0 ? 2 : 1);
                else         s += img[r+dr][c+dc];
        case (md)
            0: v = s / 16;
            1: v = (s * 57) / 512;
            2: begin v = 8 * ctr - (s - ctr); if (v < 0) v = -v; end
            default: v = ctr;
        endcase
        return (v > 255) ? 255 : v;
    endfunction

    // Called just after a negedge; returns just after the following negedge.
    task automatic send_pix(input int p, input bit sof, input int gaps);
        exp_t e;
        for (int g = 0; g < gaps; g++) begin
            vld_i = 0; sof_i = 0;
            @(negedge clk);
        end
        vld_i = 1; sof_i = sof; pix_i = DW'(p);
        if (sof) begin m_r = 0; m_c = 0; m_mode = int'(mode_i); end
        img[m_r][m_c] = p;
        @(posedge clk);
        if (m_r >= 2 && m_c >= 2) begin
            e.px = model_px(m_mode, m_r - 1, m_c - 1);
            e.dn = (m_r == H-1 && m_c == W-1) ? 1 : 0;
            e.t  = $time;
            exp_q.push_back(e);
        end
        if (m_c == W-1) begin m_c = 0; m_r = (m_r == H-1) ? 0 : m_r + 1; end
        else m_c++;
        @(negedge clk);
        vld_i = 0; sof_i = 0;
    endtask

    // kind: 0 constant val, 1 impulse of val at (1,1), 2 random
    task automatic send_frame(input int md, input int kind, input int val, input int gapmax,
                              input bit sof, input bit sw, input int npix);
        int p;
        for (int i = 0; i < npix; i++) begin
            mode_i = (sw && i > 0) ? 2'd2 : 2'(md);
            case (kind)
                0: p = val;
                1: p = (i == W + 1) ? val : 0;
                default: p = int'($urandom_range(0, 255));
            endcase
            send_pix(p, sof && i == 0, (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0);
        end
    endtask

    task automatic drain();
        repeat (8) @(negedge clk);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (vld_o) begin
                if (exp_q.size() == 0) chk("spurious_vld", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("pix", pix_o, e.px);
                    chk("done", done_o, e.dn);
                    chk("latency", $time - e.t, 3*P + P/2);
                    if (done_o) n_done++;
                end
            end else if (done_o) chk("done_idle", done_o, 0);
        end
    end

    initial begin
        #(200000 * P);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int d0;
        rst_n = 0; sof_i = 0; vld_i = 0; pix_i = '0; mode_i = 2'd0;
        repeat (3) @(negedge clk);
        chk("rst_vld", vld_o, 0);
        chk("rst_pix", pix_o, 0);
        chk("rst_done", done_o, 0);
        rst_n = 1;
        @(negedge clk);

        for (int md = 0; md < 4; md++) begin
            d0 = n_done;
            send_frame(md, 0, 100, 0, 1, 0, W*H);
            drain();
            chk("const_done_cnt", n_done - d0, 1);
        end
        send_frame(0, 1, 255, 0, 1, 0, W*H); drain();
        send_frame(2, 1, 255, 0, 1, 0, W*H); drain();
        send_frame(1, 0, 255, 2, 1, 0, W*H); drain();
        for (int k = 0; k < 6; k++) begin
            send_frame(k % 4, 2, 0, (k % 2) * 3, 1, 0, W*H);
            drain();
        end
        send_frame(0, 2, 0, 0, 1, 1, W*H); drain();
        send_frame(2, 2, 0, 1, 1, 0, W*H); drain();

        d0 = n_done;
        send_frame(1, 2, 0, 0, 1, 0, W*H);
        send_frame(1, 2, 0, 0, 0, 0, W*H);
        drain();
        chk("b2b_done_cnt", n_done - d0, 2);

        d0 = n_done;
        send_frame(3, 2, 0, 0, 1, 0, 20);
        send_frame(0, 2, 0, 0, 1, 0, W*H);
        drain();
        chk("abort_done_cnt", n_done - d0, 1);

        send_frame(2, 2, 0, 0, 1, 0, 20);
        drain();
        rst_n = 0;
        m_r = 0; m_c = 0; m_mode = 0;
        exp_q.delete();
        @(negedge clk);
        chk("mid_rst_vld", vld_o, 0);
        chk("mid_rst_pix", pix_o, 0);
        chk("mid_rst_done", done_o, 0);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        d0 = n_done;
        send_frame(1, 2, 0, 0, 1, 0, W*H);
        drain();
        chk("post_rst_done_cnt", n_done - d0, 1);

        chk("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
